// File: rtl/fetch_stage_if.sv
`timescale 1ns/1ps
// Instruction-memory port of the fetch stage: a level request with a stable
// address, completed by a one-cycle valid pulse carrying the instruction word.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output imem_valid
    );
endinterface

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding,
// buffers a word across decode stalls, drains redirected requests and stops on HLT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [15:0]   br_target,
    fetch_stage_if.master imem,
    output logic [15:0]   F_instruction,
    output logic [15:0]   F_incPC,
    output logic [15:0]   F_PC,
    output logic          F_hlt,
    output logic          F_valid
);

    localparam int unsigned XLEN = 16;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_nxt;
    logic [XLEN-1:0]   buffer;
    logic [XLEN-1:0]   buffer_nxt;
    logic [XLEN-1:0]   pc_inc_c;

    logic              req_c;
    logic              valid_c;
    logic              hlt_c;
    logic [XLEN-1:0]   instr_c;
    logic              mem_hlt_c;
    logic              buf_hlt_c;

    assign pc_inc_c  = pc + XLEN'(2);
    assign mem_hlt_c = (imem.imem_data[15:12] == HLT_OPCODE);
    assign buf_hlt_c = (buffer[15:12] == HLT_OPCODE);

    // State, PC and hold buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            buffer <= NOP_INSTR;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            buffer <= buffer_nxt;
        end
    end

    // Next state and presented instruction; a redirect always outranks a stall
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        buffer_nxt = buffer;
        req_c      = 1'b0;
        valid_c    = 1'b0;
        hlt_c      = 1'b0;
        instr_c    = NOP_INSTR;

        unique case (state)
            FETCH: begin
                req_c = 1'b1;
                if (imem.imem_valid) begin
                    if (br_taken) begin
                        pc_nxt = br_target;
                    end else begin
                        valid_c = 1'b1;
                        instr_c = imem.imem_data;
                        hlt_c   = mem_hlt_c;
                        if (stall) begin
                            buffer_nxt = imem.imem_data;
                            state_nxt  = HOLD;
                        end else if (mem_hlt_c) begin
                            state_nxt = HALT;
                        end else begin
                            pc_nxt = pc_inc_c;
                        end
                    end
                end else if (br_taken) begin
                    // The in-flight request cannot be cancelled, so wait it out
                    pc_nxt    = br_target;
                    state_nxt = DRAIN;
                end
            end

            HOLD: begin
                if (br_taken) begin
                    pc_nxt     = br_target;
                    buffer_nxt = NOP_INSTR;
                    state_nxt  = FETCH;
                end else begin
                    valid_c = 1'b1;
                    instr_c = buffer;
                    hlt_c   = buf_hlt_c;
                    if (!stall) begin
                        if (buf_hlt_c) begin
                            state_nxt = HALT;
                        end else begin
                            pc_nxt    = pc_inc_c;
                            state_nxt = FETCH;
                        end
                    end
                end
            end

            DRAIN: begin
                if (br_taken) begin
                    pc_nxt = br_target;
                end
                if (imem.imem_valid) begin
                    state_nxt = FETCH;
                end
            end

            HALT: begin
                if (br_taken) begin
                    pc_nxt    = br_target;
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Reset forces the idle values even while a response is on the bus
    assign imem.imem_req  = req_c & ~rst;
    assign imem.imem_addr = pc;
    assign F_valid        = valid_c & ~rst;
    assign F_hlt          = hlt_c & ~rst;
    assign F_instruction  = rst ? NOP_INSTR : instr_c;
    assign F_PC           = pc;
    assign F_incPC        = pc_inc_c;

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// Self-checking bench for fetch_stage: variable-latency memory model, a flag-based
// behavioural model compared every cycle, directed scenarios then random traffic.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0000;

    typedef struct {
        int          lat;
        logic [15:0] data;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] F_instruction;
    logic [15:0] F_incPC;
    logic [15:0] F_PC;
    logic        F_hlt;
    logic        F_valid;

    fetch_stage_if mif();

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .imem          (mif),
        .F_instruction (F_instruction),
        .F_incPC       (F_incPC),
        .F_PC          (F_PC),
        .F_hlt         (F_hlt),
        .F_valid       (F_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: PC plus three flags describing what fetch is waiting on
    logic [15:0] m_pc;
    logic [15:0] m_word;
    bit          m_held;
    bit          m_stale;
    bit          m_halted;
    bit          e_valid;
    bit          e_hlt;
    bit          e_req;
    logic [15:0] e_instr;

    // Memory model
    bit          mem_busy;
    int          mem_cnt;
    logic [15:0] mem_addr;
    logic [15:0] mem_word;
    mreq_t       forced_q[$];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 99) < 10) w[15:12] = 4'hF;
        else if (w[15:12] == 4'hF) w[15:12] = 4'h1;
        return w;
    endfunction

    function automatic bit is_hlt(input logic [15:0] w);
        return w[15:12] == 4'hF;
    endfunction

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_word   = NOP;
        m_held   = 1'b0;
        m_stale  = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic model_eval();
        bit fetching;
        fetching = !m_held && !m_stale && !m_halted;
        e_req    = fetching && !rst;
        e_valid  = 1'b0;
        e_instr  = NOP;
        if (!rst) begin
            if (m_held) begin
                if (!br_taken) begin
                    e_valid = 1'b1;
                    e_instr = m_word;
                end
            end else if (fetching && mif.imem_valid && !br_taken) begin
                e_valid = 1'b1;
                e_instr = mif.imem_data;
            end
        end
        e_hlt = e_valid && is_hlt(e_instr);
    endtask

    task automatic model_step();
        bit fetching;
        fetching = !m_held && !m_stale && !m_halted;
        if (rst) begin
            model_reset();
        end else if (br_taken) begin
            m_stale  = (fetching || m_stale) && !mif.imem_valid;
            m_pc     = br_target;
            m_held   = 1'b0;
            m_halted = 1'b0;
        end else if (m_stale) begin
            if (mif.imem_valid) m_stale = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (m_held) begin
            if (!stall) begin
                m_held = 1'b0;
                if (is_hlt(m_word)) m_halted = 1'b1;
                else m_pc = m_pc + 16'd2;
            end
        end else if (mif.imem_valid) begin
            if (stall) begin
                m_held = 1'b1;
                m_word = mif.imem_data;
            end else if (is_hlt(mif.imem_data)) begin
                m_halted = 1'b1;
            end else begin
                m_pc = m_pc + 16'd2;
            end
        end
    endtask

    task automatic check_cycle();
        model_eval();
        chk("F_valid", 16'(F_valid), 16'(e_valid));
        chk("F_instruction", F_instruction, e_instr);
        chk("F_hlt", 16'(F_hlt), 16'(e_hlt));
        chk("F_PC", F_PC, m_pc);
        chk("F_incPC", F_incPC, m_pc + 16'd2);
        chk("imem_req", 16'(mif.imem_req), 16'(e_req));
        if (e_req) chk("imem_addr", mif.imem_addr, m_pc);
        if (mem_busy && mif.imem_req) chk("imem_addr_stable", mif.imem_addr, mem_addr);
    endtask

    // Apply inputs at the falling edge, answer memory, then compare against the model
    task automatic drive(input bit r, input bit s, input bit b, input logic [15:0] t);
        mreq_t q;
        @(negedge clk);
        rst       = r;
        stall     = s;
        br_taken  = b;
        br_target = t;
        if (r) begin
            mem_busy = 1'b0;
            forced_q.delete();
            model_reset();
        end
        #1;
        if (!r && !mem_busy && mif.imem_req) begin
            mem_busy = 1'b1;
            mem_addr = mif.imem_addr;
            if (forced_q.size() > 0) begin
                q        = forced_q.pop_front();
                mem_cnt  = q.lat;
                mem_word = q.data;
            end else begin
                mem_cnt  = int'($urandom_range(0, 3));
                mem_word = rand_word();
            end
        end
        mif.imem_valid = mem_busy && (mem_cnt == 0);
        mif.imem_data  = mif.imem_valid ? mem_word : 16'($urandom);
        #1;
        check_cycle();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        if (mem_busy) begin
            if (mif.imem_valid) mem_busy = 1'b0;
            else mem_cnt--;
        end
    endtask

    // Redirect to a PC and wait until any stale response has been drained
    task automatic goto_pc(input logic [15:0] t);
        int n;
        n = 0;
        drive(1'b0, 1'b0, 1'b1, t);
        tick();
        while (m_stale && n < 20) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0000);
            tick();
            n++;
        end
        if (m_stale) begin
            n_cmp++;
            n_err++;
            $display("FAIL goto_drain: still draining after %0d cycles, required 0", n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    initial begin
        bit r;
        bit s;
        bit b;
        rst            = 1'b1;
        stall          = 1'b0;
        br_taken       = 1'b0;
        br_target      = 16'h0000;
        mif.imem_valid = 1'b0;
        mif.imem_data  = 16'h0000;
        mem_busy       = 1'b0;
        mem_cnt        = 0;
        mem_addr       = 16'h0000;
        mem_word       = 16'h0000;
        model_reset();

        // Reset values
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("rst_valid", 16'(F_valid), 16'h0000);
        chk("rst_pc", F_PC, 16'h0000);
        chk("rst_incpc", F_incPC, 16'h0002);
        chk("rst_instr", F_instruction, 16'h0000);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();

        // Two one-cycle-latency fetches
        forced_q.push_back('{1, 16'h1234});
        forced_q.push_back('{1, 16'h2345});
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("seq_addr0", mif.imem_addr, 16'h0000);
        chk("seq_wait0", 16'(F_valid), 16'h0000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("seq_valid0", 16'(F_valid), 16'h0001);
        chk("seq_instr0", F_instruction, 16'h1234);
        chk("seq_pc0", F_PC, 16'h0000);
        chk("seq_inc0", F_incPC, 16'h0002);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("seq_addr2", mif.imem_addr, 16'h0002);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("seq_instr2", F_instruction, 16'h2345);
        chk("seq_pc2", F_PC, 16'h0002);
        chk("seq_inc2", F_incPC, 16'h0004);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("seq_addr4", mif.imem_addr, 16'h0004);
        tick();

        // Stall while a word returns: held and re-presented
        goto_pc(16'h0010);
        forced_q.push_back('{0, 16'hABCD});
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0000);
            chk("hold_instr", F_instruction, 16'hABCD);
            chk("hold_valid", 16'(F_valid), 16'h0001);
            if (i > 0) chk("hold_req", 16'(mif.imem_req), 16'h0000);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("hold_release", F_instruction, 16'hABCD);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("hold_next_addr", mif.imem_addr, 16'h0012);
        tick();

        // Redirect during a four-cycle request: drain the stale response
        goto_pc(16'h0020);
        forced_q.push_back('{3, 16'h5555});
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("drain_addr", mif.imem_addr, 16'h0020);
        tick();
        drive(1'b0, 1'b0, 1'b1, 16'h0100);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("drain_req", 16'(mif.imem_req), 16'h0000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("drain_stale_valid", 16'(F_valid), 16'h0000);
        chk("drain_stale_instr", F_instruction, 16'h0000);
        tick();

        // Redirect coinciding with a response, then redirect+stall in the hold buffer
        forced_q.push_back('{0, 16'h1111});
        drive(1'b0, 1'b0, 1'b1, 16'h0200);
        chk("brv_addr", mif.imem_addr, 16'h0100);
        chk("brv_valid", 16'(F_valid), 16'h0000);
        tick();
        forced_q.push_back('{0, 16'h2222});
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("brv_next_addr", mif.imem_addr, 16'h0200);
        tick();
        drive(1'b0, 1'b1, 1'b1, 16'h0300);
        chk("brhold_valid", 16'(F_valid), 16'h0000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("brhold_addr", mif.imem_addr, 16'h0300);
        tick();

        // HLT delivered once, then fetch stops until a redirect
        goto_pc(16'h0040);
        forced_q.push_back('{1, 16'hF000});
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("hlt_flag", 16'(F_hlt), 16'h0001);
        chk("hlt_valid", 16'(F_valid), 16'h0001);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0000);
            chk("halt_flag", 16'(F_hlt), 16'h0000);
            chk("halt_req", 16'(mif.imem_req), 16'h0000);
            chk("halt_pc", F_PC, 16'h0040);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 16'h0008);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("halt_resume", mif.imem_addr, 16'h0008);
        chk("halt_resume_req", 16'(mif.imem_req), 16'h0001);
        tick();

        // PC wrap, then reset in the middle of a pending request
        goto_pc(16'hFFFE);
        forced_q.push_back('{0, 16'h1234});
        forced_q.push_back('{3, 16'h4321});
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("wrap_inc", F_incPC, 16'h0000);
        chk("wrap_valid", 16'(F_valid), 16'h0001);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("wrap_addr", mif.imem_addr, 16'h0000);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("midrst_valid", 16'(F_valid), 16'h0000);
        chk("midrst_pc", F_PC, 16'h0000);
        chk("midrst_inc", F_incPC, 16'h0002);
        chk("midrst_hlt", 16'(F_hlt), 16'h0000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("midrst_refetch", mif.imem_addr, 16'h0000);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 399) == 0);
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 8);
            drive(r, s, b, 16'($urandom) & 16'hFFFE);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
